// File: rtl/prim_sync_flop.sv
// prim_sync_flop: parameterized D flip-flop with synchronous active-low reset
// to a parameter value. The optional hardened mode keeps a complemented
// shadow copy and raises err_o while any bit pair stops being complementary.
module prim_sync_flop #(
  parameter int unsigned            Width      = 1,
  parameter logic [Width-1:0]       ResetValue = '0,
  parameter bit                     Hardened   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic             err_o
);

  // Main storage. Marked so synthesis never merges it with the shadow copy.
  (* keep = "true", dont_touch = "true" *) logic [Width-1:0] r_q;

  // Capture d_i every edge; reset value wins over d_i on a reset edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_q <= ResetValue;
    else         r_q <= d_i;
  end

  assign q_o = r_q;

  if (Hardened) begin : g_shadow
    // Complemented copy: holds ~r_q in fault-free operation.
    (* keep = "true", dont_touch = "true" *) logic [Width-1:0] r_s;
    logic [Width-1:0] w_pair;

    // Shadow tracks the inverse of whatever the main register loads.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) r_s <= ~ResetValue;
      else         r_s <= ~d_i;
    end

    // Every bit pair must differ; any equal pair is a storage fault.
    // Combinational so it follows the current contents (not sticky).
    assign w_pair = r_q ^ r_s;
    assign err_o  = ~&w_pair;
  end else begin : g_plain
    assign err_o = 1'b0;
  end

endmodule

// File: tb/tb_prim_sync_flop.sv
// Directed plus randomized bench for prim_sync_flop across several
// parameterizations; expected values come from a simple "last sampled
// input or reset value" model held in the bench.
module tb_prim_sync_flop;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Width=8, ResetValue=A5, plain
  logic       rst8, err8;
  logic [7:0] d8, q8;
  // Width=4, ResetValue=F, plain
  logic       rst4, err4;
  logic [3:0] d4, q4;
  // Width=8, ResetValue=0F, hardened
  logic       rsth, errh;
  logic [7:0] dh, qh;
  // Width=1, plain
  logic       rst1, d1, q1, err1;
  // Width=64, ResetValue=all-ones, hardened
  logic        rst64, err64;
  logic [63:0] d64, q64;

  prim_sync_flop #(.Width(8), .ResetValue(8'hA5), .Hardened(1'b0)) u8 (
    .clk_i(clk), .rst_ni(rst8), .d_i(d8), .q_o(q8), .err_o(err8));
  prim_sync_flop #(.Width(4), .ResetValue(4'hF), .Hardened(1'b0)) u4 (
    .clk_i(clk), .rst_ni(rst4), .d_i(d4), .q_o(q4), .err_o(err4));
  prim_sync_flop #(.Width(8), .ResetValue(8'h0F), .Hardened(1'b1)) uh (
    .clk_i(clk), .rst_ni(rsth), .d_i(dh), .q_o(qh), .err_o(errh));
  prim_sync_flop #(.Width(1), .ResetValue(1'b0), .Hardened(1'b0)) u1 (
    .clk_i(clk), .rst_ni(rst1), .d_i(d1), .q_o(q1), .err_o(err1));
  prim_sync_flop #(.Width(64), .ResetValue({64{1'b1}}), .Hardened(1'b1)) u64 (
    .clk_i(clk), .rst_ni(rst64), .d_i(d64), .q_o(q64), .err_o(err64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and step 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  seq [4];
  logic [7:0]  exph;
  logic [63:0] exp64;
  logic [7:0]  fv;
  logic        r_h, r_64;

  initial begin
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h5A; seq[3] = 8'h81;
    rst8 = 1'b0; d8 = 8'h3C;
    rst4 = 1'b0; d4 = 4'h0;
    rsth = 1'b0; dh = 8'h55;
    rst1 = 1'b0; d1 = 1'b1;
    rst64 = 1'b0; d64 = 64'h0123_4567_89AB_CDEF;

    // Two reset edges with data present: reset wins
    tick();
    chk("err1_in_reset", 64'(err1), 64'h0);
    tick();
    chk("q8_reset", 64'(q8), 64'hA5);
    chk("q4_reset", 64'(q4), 64'hF);
    chk("qh_reset", 64'(qh), 64'h0F);
    chk("sh_reset", 64'(uh.g_shadow.r_s), 64'hF0);
    chk("errh_reset", 64'(errh), 64'h0);
    chk("q64_reset", q64, {64{1'b1}});
    chk("err64_reset", 64'(err64), 64'h0);
    chk("q1_reset", 64'(q1), 64'h0);
    chk("err1_reset", 64'(err1), 64'h0);
    chk("err8_const", 64'(err8), 64'h0);

    // Release u8: next edge captures 3C
    rst8 = 1'b1;
    tick();
    chk("q8_release", 64'(q8), 64'h3C);

    // Sequence shows up one edge later, unchanged until captured
    for (int i = 0; i < 4; i++) begin
      d8 = seq[i];
      #2;
      chk("q8_pre_edge", 64'(q8), (i == 0) ? 64'h3C : 64'(seq[i-1]));
      tick();
      chk("q8_seq", 64'(q8), 64'(seq[i]));
    end
    // Mid-cycle change of d does not disturb q
    d8 = 8'h33;
    #2;
    chk("q8_midcycle", 64'(q8), 64'h81);
    d8 = 8'hC7;
    #2;
    chk("q8_midcycle2", 64'(q8), 64'h81);
    tick();
    chk("q8_after_mid", 64'(q8), 64'hC7);

    // u4: load 2, then a reset edge with d=7 pending
    rst4 = 1'b1; d4 = 4'h2;
    tick();
    chk("q4_load2", 64'(q4), 64'h2);
    rst4 = 1'b0; d4 = 4'h7;
    #2;
    chk("q4_no_async", 64'(q4), 64'h2);
    tick();
    chk("q4_reset_mid", 64'(q4), 64'hF);
    rst4 = 1'b1;
    tick();
    chk("q4_resume", 64'(q4), 64'h7);

    // Width=1 toggling; err stays 0
    rst1 = 1'b1;
    d1 = 1'b0; tick(); chk("q1_t0", 64'(q1), 64'h0); chk("err1_t0", 64'(err1), 64'h0);
    d1 = 1'b1; tick(); chk("q1_t1", 64'(q1), 64'h1); chk("err1_t1", 64'(err1), 64'h0);
    d1 = 1'b0; tick(); chk("q1_t2", 64'(q1), 64'h0); chk("err1_t2", 64'(err1), 64'h0);

    // Hardened instances: random data with occasional mid-stream resets
    rsth = 1'b1; rst64 = 1'b1;
    for (int c = 0; c < 100; c++) begin
      r_h  = ($urandom_range(0, 19) != 0);
      r_64 = ($urandom_range(0, 19) != 0);
      rsth = r_h;  rst64 = r_64;
      dh   = 8'($urandom);
      d64  = {32'($urandom), 32'($urandom)};
      if ((c % 25) == 0) dh = (c % 50 == 0) ? 8'hFF : 8'h00;
      exph  = r_h  ? dh  : 8'h0F;
      exp64 = r_64 ? d64 : {64{1'b1}};
      tick();
      chk("qh_rand", 64'(qh), 64'(exph));
      chk("errh_rand", 64'(errh), 64'h0);
      chk("q64_rand", q64, exp64);
      chk("err64_rand", 64'(err64), 64'h0);
    end

    // Fault injection: flip bit 3 of the main register
    rsth = 1'b1;
    dh = 8'h96;
    tick();
    chk("qh_prefault", 64'(qh), 64'h96);
    fv = 8'h96 ^ 8'h08;
    force uh.r_q = fv;
    #1;
    chk("errh_fault", 64'(errh), 64'h1);
    release uh.r_q;
    #1;
    chk("errh_fault_held", 64'(errh), 64'h1);
    dh = 8'h3B;
    tick();
    chk("errh_recover", 64'(errh), 64'h0);
    chk("qh_recover", 64'(qh), 64'h3B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prim_sync_flop.md
Name: prim_sync_flop

Overview:
- Parameterized multi-bit D flip-flop primitive: the single point of state storage for hardened primitives such as the dual cross-counter.
- Stores `d_i` every clock cycle and presents it on `q_o`.
- Reset loads a parameter-defined value, so callers can initialise counters to non-zero values (e.g. a down-counter's secondary at all-ones).
- Optional hardened mode keeps a complemented shadow copy and flags any mismatch, detecting faults injected into the storage.

Parameters:
- Width, 1, data width in bits (legal range 1..256).
- ResetValue, '0 (Width bits), value loaded into `q_o` during reset.
- Hardened, 0, 1 = instantiate the complemented shadow register and drive `err_o`; 0 = `err_o` tied to 0 and no shadow logic.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- d_i  input  Width  next-state data.
- q_o  output  Width  registered data.
- err_o  output  1  storage integrity error; may be left unconnected.

Behaviour:
- One clock (`clk_i`); reset `rst_ni` is synchronous and active-low.
- Reset: on a rising edge with `rst_ni`=0, `q_o` <= ResetValue.
  - Reset has priority over `d_i`.
  - No asynchronous path: between reset assertion and the next edge, `q_o` holds its previous value.
- Normal operation: on every rising edge with `rst_ni`=1, `q_o` <= `d_i`.
  - No enable input: callers implement hold by feeding back `q_o`.
  - Latency is exactly 1 cycle.
- `q_o` is driven directly from the main register, with no combinational path from `d_i`.
- Before the first reset edge, `q_o` is undefined (X in simulation). Callers must reset before use.
- Hardened=1:
  - Shadow register `s` of Width bits.
  - Reset: `s` <= ~ResetValue. Otherwise `s` <= ~`d_i` on the same edge as `q_o`.
  - `err_o` = combinational (`q_o` ^ `s`) != all-ones, i.e. asserted if any bit pair fails to be complementary.
  - `err_o` is 0 after reset and stays 0 in fault-free operation.
  - `err_o` is not sticky: it follows the current register contents.
  - Synthesis must preserve both registers; they must not be merged or optimised away. Mark them keep / dont_touch.
- Hardened=0: `err_o` = 0 constant and no shadow register exists.
- Width=1 and wide widths (e.g. 64) behave identically per bit.
- No reset-value check on `d_i`: any value is stored verbatim, including all-ones and zero.
- Simultaneous reset and data change: the reset value wins, and `d_i` is ignored for that edge.
- Reset mid-stream: the next edge loads ResetValue (and ~ResetValue in the shadow). Normal capture resumes on the first edge after `rst_ni` returns to 1.

Test Plan:
- Width=8, ResetValue=8'hA5: hold `rst_ni`=0 for 2 edges with `d_i`=8'h3C → `q_o`=8'hA5. Release reset → next edge `q_o`=8'h3C.
- Width=8: drive `d_i` sequence 00, FF, 5A, 81 on consecutive edges → `q_o` shows the same sequence delayed by exactly one cycle. Changing `d_i` mid-cycle does not change `q_o` until the next edge.
- Width=4, ResetValue=4'hF: assert `rst_ni`=0 for one edge while `q_o`=4'h2 → `q_o` stays 4'h2 until the edge, then 4'hF. The next edge with `rst_ni`=1 and `d_i`=4'h7 → `q_o`=4'h7.
- Hardened=1, Width=8, ResetValue=8'h0F: after reset `err_o`=0 and the shadow holds 8'hF0. Random `d_i` for 100 cycles → `err_o` is always 0.
- Hardened=1: force one bit of the main register (bit 3) via the bench → `err_o`=1 combinationally. Release and load new `d_i` → `err_o` returns to 0 on the next edge.
- Hardened=0, Width=1: toggle `d_i` 0,1,0 → `q_o` follows one cycle later. `err_o` is constant 0 throughout, including during reset.
